// File: rtl/usb_stuff_nrzi_tx.sv
// USB TX back-end: bit stuffing, NRZI encode and EOP line drive, one raw bit per cycle.
// Accepted bit reaches dp/dm one cycle later; stall is high for the single cycle a stuff 0 is inserted.
module usb_stuff_nrzi_tx #(
    parameter int MAX_RUN     = 6,
    parameter int EOP_SE0_CYC = 2,
    parameter int EOP_J_CYC   = 1,
    parameter int SCNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_L,
    input  logic              bit_in,
    input  logic              start,
    input  logic              last,
    output logic              stall,
    output logic              dp,
    output logic              dm,
    output logic              oe,
    output logic              busy,
    output logic [SCNT_W-1:0] stuff_count
);

    localparam int ECMAX = (EOP_SE0_CYC > EOP_J_CYC) ? EOP_SE0_CYC : EOP_J_CYC;
    localparam int ECW   = (ECMAX > 1) ? $clog2(ECMAX) : 1;
    localparam logic [3:0] RUN_MAX = 4'(MAX_RUN);
    localparam logic [ECW-1:0] SE0_LOAD = ECW'(EOP_SE0_CYC - 1);
    localparam logic [ECW-1:0] J_LOAD   = ECW'(EOP_J_CYC - 1);

    typedef enum logic [2:0] {IDLE, DATA, STUFF, EOP_SE0, EOP_J} state_t;

    state_t            state, state_nx;
    logic              level, level_nx;
    logic [3:0]        run, run_nx;
    logic [3:0]        run_inc;
    logic              last_pend, last_pend_nx;
    logic [SCNT_W-1:0] scnt_nx;
    logic [ECW-1:0]    ecnt, ecnt_nx;
    logic              dp_nx, dm_nx, oe_nx;
    logic              enc;

    assign run_inc = run + 4'd1;
    assign enc     = bit_in ? level : ~level;
    assign stall   = (state == STUFF);
    // line stays owned until the trailing J has been shown with oe=1
    assign busy    = (state != IDLE) | oe;

    always_comb begin
        state_nx     = state;
        level_nx     = level;
        run_nx       = run;
        last_pend_nx = last_pend;
        scnt_nx      = stuff_count;
        ecnt_nx      = ecnt;
        dp_nx        = dp;
        dm_nx        = dm;
        oe_nx        = oe;
        case (state)
            IDLE: begin
                dp_nx    = 1'b1;
                dm_nx    = 1'b0;
                oe_nx    = 1'b0;
                level_nx = 1'b1;
                run_nx   = 4'd0;
                if (start) begin
                    level_nx = enc;
                    dp_nx    = enc;
                    dm_nx    = ~enc;
                    oe_nx    = 1'b1;
                    run_nx   = bit_in ? 4'd1 : 4'd0;
                    scnt_nx  = '0;
                    if (last) begin
                        state_nx = EOP_SE0;
                        ecnt_nx  = SE0_LOAD;
                    end else begin
                        state_nx = DATA;
                    end
                end
            end
            DATA: begin
                level_nx     = enc;
                dp_nx        = enc;
                dm_nx        = ~enc;
                run_nx       = bit_in ? run_inc : 4'd0;
                last_pend_nx = last;
                if (bit_in && (run_inc == RUN_MAX)) begin
                    state_nx = STUFF;
                end else if (last) begin
                    state_nx = EOP_SE0;
                    ecnt_nx  = SE0_LOAD;
                end
            end
            STUFF: begin
                level_nx = ~level;
                dp_nx    = ~level;
                dm_nx    = level;
                run_nx   = 4'd0;
                if (stuff_count != {SCNT_W{1'b1}})
                    scnt_nx = stuff_count + SCNT_W'(1);
                if (last_pend) begin
                    state_nx = EOP_SE0;
                    ecnt_nx  = SE0_LOAD;
                end else begin
                    state_nx = DATA;
                end
            end
            EOP_SE0: begin
                dp_nx = 1'b0;
                dm_nx = 1'b0;
                oe_nx = 1'b1;
                if (ecnt == '0) begin
                    state_nx = EOP_J;
                    ecnt_nx  = J_LOAD;
                end else begin
                    ecnt_nx = ecnt - ECW'(1);
                end
            end
            EOP_J: begin
                dp_nx = 1'b1;
                dm_nx = 1'b0;
                oe_nx = 1'b1;
                if (ecnt == '0) begin
                    state_nx = IDLE;
                    level_nx = 1'b1;
                    run_nx   = 4'd0;
                end else begin
                    ecnt_nx = ecnt - ECW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_L) begin
        if (!rst_L) begin
            state       <= IDLE;
            level       <= 1'b1;
            run         <= 4'd0;
            last_pend   <= 1'b0;
            stuff_count <= '0;
            ecnt        <= '0;
            dp          <= 1'b1;
            dm          <= 1'b0;
            oe          <= 1'b0;
        end else begin
            state       <= state_nx;
            level       <= level_nx;
            run         <= run_nx;
            last_pend   <= last_pend_nx;
            stuff_count <= scnt_nx;
            ecnt        <= ecnt_nx;
            dp          <= dp_nx;
            dm          <= dm_nx;
            oe          <= oe_nx;
        end
    end

endmodule

// File: tb/tb_usb_stuff_nrzi_tx.sv
// Bench for usb_stuff_nrzi_tx: default instance plus a MAX_RUN=3 / SCNT_W=2 instance,
// each checked cycle by cycle against a stream-level stuffing/NRZI/EOP model.
module tb_usb_stuff_nrzi_tx;

    typedef bit bq_t[$];

    localparam int SE0 = 2;
    localparam int JC  = 1;

    logic       clk = 1'b0;
    logic       rst_L;
    logic [1:0] bit_in, start, last;
    wire  [1:0] stall, dp, dm, oe, busy;
    wire  [7:0] sc0;
    wire  [1:0] sc1;

    int errors = 0;
    int checks = 0;
    int mr   [2] = '{6, 3};
    int smax [2] = '{255, 3};

    always #5 clk = ~clk;

    usb_stuff_nrzi_tx u_dut0 (
        .clk(clk), .rst_L(rst_L), .bit_in(bit_in[0]), .start(start[0]), .last(last[0]),
        .stall(stall[0]), .dp(dp[0]), .dm(dm[0]), .oe(oe[0]), .busy(busy[0]), .stuff_count(sc0)
    );

    usb_stuff_nrzi_tx #(.MAX_RUN(3), .SCNT_W(2)) u_dut1 (
        .clk(clk), .rst_L(rst_L), .bit_in(bit_in[1]), .start(start[1]), .last(last[1]),
        .stall(stall[1]), .dp(dp[1]), .dm(dm[1]), .oe(oe[1]), .busy(busy[1]), .stuff_count(sc1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] scnt(input int u);
        return (u == 0) ? 32'(sc0) : 32'(sc1);
    endfunction

    function automatic bq_t mk(input logic [31:0] v, input int n);
        bq_t q;
        for (int i = n - 1; i >= 0; i--) q.push_back(v[i]);
        return q;
    endfunction

    function automatic bq_t rnd_pkt(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back($urandom_range(0, 3) != 0);
        return q;
    endfunction

    task automatic idle(input int u, input int n);
        for (int i = 0; i < n; i++) begin
            start[u]  = 1'b0;
            last[u]   = 1'($urandom);
            bit_in[u] = 1'($urandom);
            tick;
            chk("idle_dp", 32'(dp[u]), 1);
            chk("idle_oe", 32'(oe[u]), 0);
            chk("idle_busy", 32'(busy[u]), 0);
        end
    endtask

    // Expected line = stuffed stream NRZI-coded from J, then SE0, J, release.
    task automatic run_packet(input int u, input bq_t pk, input bit junk);
        bit         sb[$];
        bit         is_st[$];
        logic [2:0] ex[$];
        logic       lvl;
        int         n, s, len, run, nst, idx, exp_sc;
        logic       st;
        n   = pk.size();
        run = 0;
        nst = 0;
        foreach (pk[i]) begin
            sb.push_back(pk[i]);
            is_st.push_back(1'b0);
            run = pk[i] ? run + 1 : 0;
            if (run == mr[u]) begin
                sb.push_back(1'b0);
                is_st.push_back(1'b1);
                run = 0;
                nst++;
            end
        end
        lvl = 1'b1;
        foreach (sb[i]) begin
            if (!sb[i]) lvl = ~lvl;
            ex.push_back({lvl, ~lvl, 1'b1});
        end
        repeat (SE0) ex.push_back(3'b001);
        repeat (JC)  ex.push_back(3'b101);
        ex.push_back(3'b100);
        s   = sb.size();
        len = ex.size();
        idx = 0;
        for (int j = 0; j < len; j++) begin
            st        = stall[u];
            start[u]  = (j == 0) || (junk && j >= s && j <= len - 2);
            bit_in[u] = (idx < n) ? pk[idx] : 1'($urandom);
            last[u]   = (idx < n) ? (idx == n - 1) : 1'($urandom);
            tick;
            if (!st && idx < n) idx++;
            chk("dp", 32'(dp[u]), 32'(ex[j][2]));
            chk("dm", 32'(dm[u]), 32'(ex[j][1]));
            chk("oe", 32'(oe[u]), 32'(ex[j][0]));
            chk("stall", 32'(stall[u]), (j + 1 < s) ? 32'(is_st[j + 1]) : 0);
            chk("busy", 32'(busy[u]), (j < len - 1) ? 1 : 0);
        end
        start[u] = 1'b0;
        last[u]  = 1'b0;
        exp_sc   = (nst < smax[u]) ? nst : smax[u];
        chk("consumed", idx, n);
        chk("stuff_count", scnt(u), exp_sc);
    endtask

    initial begin
        rst_L  = 1'b0;
        bit_in = '0;
        start  = '0;
        last   = '0;
        repeat (2) tick;
        for (int u = 0; u < 2; u++) begin
            chk("rst_dp", 32'(dp[u]), 1);
            chk("rst_dm", 32'(dm[u]), 0);
            chk("rst_oe", 32'(oe[u]), 0);
            chk("rst_stall", 32'(stall[u]), 0);
            chk("rst_busy", 32'(busy[u]), 0);
            chk("rst_scnt", scnt(u), 0);
        end
        #2 rst_L = 1'b1;
        tick;

        // reset landing in the middle of a packet
        start[0]  = 1'b1;
        bit_in[0] = 1'b0;
        tick;
        start[0] = 1'b0;
        repeat (3) tick;
        chk("pre_rst_oe", 32'(oe[0]), 1);
        #2 rst_L = 1'b0;
        #1;
        chk("arst_dp", 32'(dp[0]), 1);
        chk("arst_dm", 32'(dm[0]), 0);
        chk("arst_oe", 32'(oe[0]), 0);
        chk("arst_stall", 32'(stall[0]), 0);
        chk("arst_busy", 32'(busy[0]), 0);
        #2 rst_L = 1'b1;
        tick;

        run_packet(0, mk(32'h01, 8), 1'b1);
        run_packet(0, mk(32'h1, 1), 1'b0);
        idle(0, 2);
        run_packet(0, mk(32'h0FF, 9), 1'b0);
        run_packet(0, mk(32'h3F, 8), 1'b1);
        run_packet(0, mk(32'h7F, 7), 1'b0);
        for (int k = 0; k < 30; k++) begin
            run_packet(0, rnd_pkt($urandom_range(1, 20)), 1'($urandom));
            idle(0, $urandom_range(0, 3));
        end

        run_packet(1, mk(32'hFFF, 12), 1'b0);
        chk("sat_scnt", scnt(1), 3);
        idle(1, 1);
        for (int k = 0; k < 15; k++) begin
            run_packet(1, rnd_pkt($urandom_range(1, 16)), 1'($urandom));
            idle(1, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
